// File: rtl/matrix_operand_loader_if.sv
// Element-stream and adder-operand bundle for matrix_operand_loader.
// MATLOAD_ABORT_EN adds the s_abort request line.
interface matrix_operand_loader_if #(
    parameter int ELEM_W = 16,
    parameter int N_ELEM = 16
);
    logic                     s_valid;
    logic                     s_ready;
    logic [ELEM_W-1:0]        s_data;
    logic                     s_op;
`ifdef MATLOAD_ABORT_EN
    logic                     s_abort;
`endif
    logic [ELEM_W*N_ELEM-1:0] dataa;
    logic [ELEM_W*N_ELEM-1:0] datab;
    logic                     add_sub;
    logic [1:0]               in_select;
    logic                     busy;
    logic                     done;

    modport master (
        output s_valid, s_data, s_op,
`ifdef MATLOAD_ABORT_EN
        output s_abort,
`endif
        input  s_ready, dataa, datab, add_sub, in_select, busy, done
    );

    modport slave (
        input  s_valid, s_data, s_op,
`ifdef MATLOAD_ABORT_EN
        input  s_abort,
`endif
        output s_ready, dataa, datab, add_sub, in_select, busy, done
    );
endinterface

// File: rtl/matrix_operand_loader.sv
// Assembles operand matrices A then B from an element stream and issues one add/sub to the adder.
// Optional feature: define MATLOAD_ABORT_EN to honour s_abort while loading.
module matrix_operand_loader #(
    parameter int ELEM_W     = 16,
    parameter int N_ELEM     = 16,
    parameter int RESULT_LAT = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    matrix_operand_loader_if.slave bus
);
    localparam int CNT_W = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;

    typedef enum logic [1:0] {
        S_LOAD_A,
        S_LOAD_B,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [CNT_W-1:0]         r_cnt;
    logic [CNT_W-1:0]         w_cnt_nxt;
    logic [3:0]               r_wcnt;
    logic [3:0]               w_wcnt_nxt;
    logic [ELEM_W*N_ELEM-1:0] r_dataa;
    logic [ELEM_W*N_ELEM-1:0] r_datab;
    logic                     r_add_sub;
    logic [1:0]               w_in_select;
    logic                     w_busy;
    logic                     w_done;
    logic                     w_loading;
    logic                     w_ready;
    logic                     w_abort;
    logic                     w_accept;
    logic                     w_last;

    assign w_loading = (r_state == S_LOAD_A) || (r_state == S_LOAD_B);
    assign w_ready   = w_loading && !reset;

`ifdef MATLOAD_ABORT_EN
    // Abort only applies before the operation is committed; it beats a same-cycle element.
    assign w_abort   = w_loading && bus.s_abort;
`else
    assign w_abort   = 1'b0;
`endif

    assign w_accept  = bus.s_valid && w_ready && !w_abort;
    assign w_last    = (r_cnt == CNT_W'(N_ELEM - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_LOAD_A;
            r_cnt   <= '0;
            r_wcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_wcnt  <= w_wcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_wcnt_nxt  = r_wcnt;
        w_in_select = 2'b11;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_LOAD_A: begin
                if (w_abort) begin
                    w_cnt_nxt = '0;
                end else if (w_accept) begin
                    if (w_last) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_LOAD_B;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            S_LOAD_B: begin
                if (w_abort) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_LOAD_A;
                end else if (w_accept) begin
                    if (w_last) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_ISSUE;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            S_ISSUE: begin
                w_in_select = 2'b00;
                w_busy      = 1'b1;
                w_wcnt_nxt  = '0;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                w_busy = 1'b1;
                // The adder result lands RESULT_LAT edges after the issue edge.
                if (r_wcnt == 4'(RESULT_LAT - 1)) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_LOAD_A;
                end else begin
                    w_wcnt_nxt = r_wcnt + 4'd1;
                end
            end
            default: begin
                w_state_nxt = S_LOAD_A;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Operands only change on accepted beats, so they stay stable through ISSUE/WAIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dataa   <= '0;
            r_datab   <= '0;
            r_add_sub <= 1'b0;
        end else if (w_accept) begin
            if (r_state == S_LOAD_A) begin
                r_dataa[ELEM_W*r_cnt +: ELEM_W] <= bus.s_data;
                if (r_cnt == '0) begin
                    r_add_sub <= bus.s_op;
                end
            end else begin
                r_datab[ELEM_W*r_cnt +: ELEM_W] <= bus.s_data;
            end
        end
    end

    assign bus.s_ready   = w_ready;
    assign bus.dataa     = r_dataa;
    assign bus.datab     = r_datab;
    assign bus.add_sub   = r_add_sub;
    assign bus.in_select = w_in_select;
    assign bus.busy      = w_busy;
    assign bus.done      = w_done;
endmodule

// File: tb/tb_matrix_operand_loader.sv
// Scoreboard bench for matrix_operand_loader with a behavioural downstream adder.
// Build with MATLOAD_ABORT_EN defined to also exercise the abort path.
module tb_matrix_operand_loader;
    localparam int ELEM_W     = 16;
    localparam int N_ELEM     = 16;
    localparam int RESULT_LAT = 1;
    localparam int MW         = ELEM_W * N_ELEM;

    typedef struct {
        logic [MW-1:0] a;
        logic [MW-1:0] b;
        logic [MW-1:0] res;
        logic          op;
    } exp_t;

    logic    clk = 1'b0;
    logic    reset;
    int      n_chk = 0;
    int      n_fail = 0;
    int      cyc = 0;
    exp_t    sb_q[$];
    logic [MW-1:0] r_sum;
    int      acc_cnt = 0;
    int      issue_cnt = 0;
    logic    issued = 1'b0;
    logic    prev_sel00 = 1'b0;
    int      last_cyc = 0;

    matrix_operand_loader_if #(.ELEM_W(ELEM_W), .N_ELEM(N_ELEM)) bus ();

    matrix_operand_loader #(
        .ELEM_W    (ELEM_W),
        .N_ELEM    (N_ELEM),
        .RESULT_LAT(RESULT_LAT)
    ) u_dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Downstream adder: registers the element-wise result on the compute edge.
    always @(posedge clk) begin
        if (bus.in_select == 2'b00) begin
            for (int k = 0; k < N_ELEM; k++) begin
                r_sum[ELEM_W*k +: ELEM_W] <= bus.add_sub ?
                    bus.dataa[ELEM_W*k +: ELEM_W] + bus.datab[ELEM_W*k +: ELEM_W] :
                    bus.dataa[ELEM_W*k +: ELEM_W] - bus.datab[ELEM_W*k +: ELEM_W];
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            acc_cnt    = 0;
            issue_cnt  = 0;
            issued     = 1'b0;
            prev_sel00 = 1'b0;
        end else begin
`ifdef MATLOAD_ABORT_EN
            if (bus.s_abort && bus.s_ready) acc_cnt = 0;
            else
`endif
            if (bus.s_valid && bus.s_ready) begin
                acc_cnt++;
                if (acc_cnt == 2 * N_ELEM) last_cyc = cyc;
            end
            if (bus.in_select == 2'b00) begin
                check_val("sel_single_cycle", {255'd0, prev_sel00}, 0);
                issue_cnt++;
                issued = 1'b1;
            end
            prev_sel00 = (bus.in_select == 2'b00);
            if (bus.busy) check_val("ready_low_busy", {255'd0, bus.s_ready}, 0);
            if (bus.done) begin
                exp_t e;
                check_val("done_after_issue", {255'd0, issued}, 1);
                check_val("done_latency", cyc - last_cyc, RESULT_LAT + 1);
                check_val("accepts", acc_cnt, 2 * N_ELEM);
                check_val("issues", issue_cnt, 1);
                check_val("sb_nonempty", {255'd0, sb_q.size() > 0}, 1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check_val("dataa", bus.dataa, e.a);
                    check_val("datab", bus.datab, e.b);
                    check_val("add_sub", {255'd0, bus.add_sub}, {255'd0, e.op});
                    check_val("result", r_sum, e.res);
                end
                acc_cnt   = 0;
                issue_cnt = 0;
                issued    = 1'b0;
            end
        end
    end

    task automatic send(input logic [ELEM_W-1:0] d, input logic op, input int gap);
        int t = 0;
        if (gap > 0) begin
            bus.s_valid = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
        end
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_op    = op;
        @(negedge clk);
        while (!bus.s_ready && t < 200) begin
            t++;
            @(negedge clk);
        end
        check_val("ready_for_beat", {255'd0, bus.s_ready}, 1);
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
    endtask

    task automatic run_txn(input logic [MW-1:0] a, input logic [MW-1:0] b, input logic op, input int gap);
        exp_t e;
        e.a  = a;
        e.b  = b;
        e.op = op;
        for (int k = 0; k < N_ELEM; k++) begin
            logic [ELEM_W-1:0] x;
            logic [ELEM_W-1:0] y;
            x = a[ELEM_W*k +: ELEM_W];
            y = b[ELEM_W*k +: ELEM_W];
            e.res[ELEM_W*k +: ELEM_W] = op ? x + y : x - y;
        end
        sb_q.push_back(e);
        for (int k = 0; k < N_ELEM; k++)
            send(a[ELEM_W*k +: ELEM_W], (k == 0) ? op : 1'($urandom), gap);
        for (int k = 0; k < N_ELEM; k++)
            send(b[ELEM_W*k +: ELEM_W], 1'($urandom), gap);
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_dataa"}, bus.dataa, 0);
        check_val({tag, "_datab"}, bus.datab, 0);
        check_val({tag, "_add_sub"}, {255'd0, bus.add_sub}, 0);
        check_val({tag, "_in_select"}, {254'd0, bus.in_select}, 3);
        check_val({tag, "_busy"}, {255'd0, bus.busy}, 0);
        check_val({tag, "_done"}, {255'd0, bus.done}, 0);
        check_val({tag, "_s_ready"}, {255'd0, bus.s_ready}, 0);
    endtask

    initial begin
        logic [MW-1:0] a;
        logic [MW-1:0] b;
        reset       = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_op    = 1'b0;
`ifdef MATLOAD_ABORT_EN
        bus.s_abort = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("rst");
        reset = 1'b0;
        @(negedge clk);
        check_val("ready_after_rst", {255'd0, bus.s_ready}, 1);
        @(posedge clk);
        #1;

        // A[k]=k+1, B=1, add; immediately followed by a subtract txn with s_valid held high
        for (int k = 0; k < N_ELEM; k++) begin
            a[ELEM_W*k +: ELEM_W] = ELEM_W'(k + 1);
            b[ELEM_W*k +: ELEM_W] = 16'h0001;
        end
        run_txn(a, b, 1'b1, 0);
        run_txn('0, b, 1'b0, 0);

        // Valid toggled every other cycle
        for (int k = 0; k < N_ELEM; k++) begin
            a[ELEM_W*k +: ELEM_W] = ELEM_W'($urandom);
            b[ELEM_W*k +: ELEM_W] = ELEM_W'($urandom);
        end
        run_txn(a, b, 1'($urandom), 1);

        // Reset after 20 beats discards the partial transaction
        for (int k = 0; k < 20; k++) send(16'hA5A5 + 16'(k), 1'b1, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_state("midrst");
        reset = 1'b0;
        @(posedge clk);
        #1;
        for (int k = 0; k < N_ELEM; k++) begin
            a[ELEM_W*k +: ELEM_W] = 16'hFFFF - ELEM_W'(k);
            b[ELEM_W*k +: ELEM_W] = 16'h8000 + ELEM_W'(k);
        end
        run_txn(a, b, 1'b1, 0);

`ifdef MATLOAD_ABORT_EN
        // Abort coinciding with B beat 10; the next accepted beat must land at A[0]
        for (int k = 0; k < N_ELEM + 10; k++) send(16'h1234, 1'b0, 0);
        bus.s_valid = 1'b1;
        bus.s_abort = 1'b1;
        bus.s_data  = 16'hDEAD;
        @(negedge clk);
        check_val("abort_ready", {255'd0, bus.s_ready}, 1);
        @(posedge clk);
        #1;
        bus.s_abort = 1'b0;
        bus.s_valid = 1'b0;
        for (int k = 0; k < N_ELEM; k++) begin
            a[ELEM_W*k +: ELEM_W] = ELEM_W'($urandom);
            b[ELEM_W*k +: ELEM_W] = ELEM_W'($urandom);
        end
        run_txn(a, b, 1'b0, 0);
`endif

        for (int t = 0; t < 50 && sb_q.size() > 0; t++) @(posedge clk);
        @(negedge clk);
        check_val("sb_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
